// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit 7-segment scan controller with history/alert arbiter.
// Define SEG_SCAN_BLANK_GAP_EN to blank seg at the start of every dwell.
module seg_scan_ctrl #(
  parameter int SCAN_DIV    = 5000,
  parameter int HOLD_FRAMES = 200,
  parameter int BLANK_CYC   = 500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       bit_valid,
  input  logic       bit_in,
  input  logic       hit,
  output logic [2:0] n,
  output logic [7:0] seg,
  output logic [6:0] codeout,
  output logic       overlay_active
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int HW = $clog2(HOLD_FRAMES + 1);

  localparam logic [DW-1:0] DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [HW-1:0] HOLD_LD = HW'(HOLD_FRAMES);
  localparam logic [HW-1:0] HOLD_1  = HW'(1);

  localparam logic [6:0] G_ZERO  = 7'b1111110;
  localparam logic [6:0] G_ONE   = 7'b0110000;
  localparam logic [6:0] G_BLANK = 7'b0000000;

  if (SCAN_DIV < 2) begin : g_chk_div
    $error("SCAN_DIV must be 2 or more");
  end
  if (HOLD_FRAMES < 1) begin : g_chk_hold
    $error("HOLD_FRAMES must be 1 or more");
  end
  if (BLANK_CYC >= SCAN_DIV) begin : g_chk_blank
    $error("BLANK_CYC must be less than SCAN_DIV");
  end

  typedef enum logic [1:0] {
    NORMAL,
    PENDING,
    OVERLAY
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic [HW-1:0] hold_cnt;
  logic [7:0]    history;
  logic [7:0]    seg_oh;
  logic          tick;
  logic          fb;
  logic          ov_nx;
  logic [2:0]    n_nx;

  assign tick = (div_cnt == DIV_MAX);
  assign fb   = tick && (n == 3'd7);
  assign n_nx = n + 3'd1;

  // Overlay ownership after this edge; the code registered now must match it.
  always_comb begin
    ov_nx = 1'b0;
    unique case (1'b1)
      state == PENDING: ov_nx = fb;
      state == OVERLAY: ov_nx = hit || !fb || (hold_cnt != HOLD_1);
      default:          ov_nx = 1'b0;
    endcase
  end

  function automatic logic [6:0] glyph(
    input logic [2:0] k,
    input logic [7:0] h,
    input logic       ov
  );
    logic [6:0] g;
    g = h[k] ? G_ONE : G_ZERO;
    if (ov) begin
      g = k[2] ? G_BLANK : ((k == 3'd1) ? G_ZERO : G_ONE);
    end
    return g;
  endfunction

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_cnt        <= '0;
      n              <= 3'd0;
      seg_oh         <= 8'b0000_0001;
      codeout        <= G_ZERO;
      history        <= 8'h00;
      state          <= NORMAL;
      hold_cnt       <= '0;
      overlay_active <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (bit_valid) begin
        history <= {history[6:0], bit_in};
      end
      if (tick) begin
        n       <= n_nx;
        seg_oh  <= 8'b0000_0001 << n_nx;
        codeout <= glyph(n_nx, history, ov_nx);
      end
      overlay_active <= ov_nx;
      unique case (state)
        NORMAL: begin
          if (hit) state <= PENDING;
        end
        PENDING: begin
          if (fb) begin
            state    <= OVERLAY;
            hold_cnt <= HOLD_LD;
          end
        end
        OVERLAY: begin
          if (hit) begin
            hold_cnt <= HOLD_LD;
          end else if (fb) begin
            if (hold_cnt == HOLD_1) state <= NORMAL;
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

`ifdef SEG_SCAN_BLANK_GAP_EN
  localparam logic [DW-1:0] BLANK_END = DW'(BLANK_CYC);
  assign seg = (div_cnt < BLANK_END) ? 8'h00 : seg_oh;
`else
  assign seg = seg_oh;
`endif

endmodule
